dec_mode_ctrl: RTL and testbench
================================

Name: dec_mode_ctrl

Overview:
- Controller that sequences the synchronous 64-bit-block / 128-bit-key decryptor core.
- Provides valid/ready streaming on both sides, key and IV loading, ECB or CBC chaining, and backpressure by gating the core's enable.
- Sits between the ciphertext source and plaintext sink.
- The core is instantiated beside it at the top level and wired through the dec_* ports.

Parameters:
- LATENCY, 8: core pipeline depth in enabled cycles; must match the core instance, and must be ≥1.
- CNT_W, 32: width of the optional block counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global enable; when 0 all state holds
- key_load  in  1  request to load new key/IV/mode
- key_in  in  128  key
- iv_in  in  64  CBC initial vector
- cbc_in  in  1  1 = CBC, 0 = ECB; captured with key
- key_ready  out  1  key loaded and no key change pending
- in_valid  in  1  ciphertext valid
- in_ready  out  1  ciphertext accepted this cycle
- in_block  in  64  ciphertext
- out_valid  out  1  plaintext valid
- out_ready  in  1  sink accepts
- out_block  out  64  plaintext
- dec_ena  out  1  core enable
- dec_in  out  64  core input block
- dec_key  out  128  core key
- dec_out  in  64  core output block
- blk_count  out  CNT_W  only with DEC_STATS_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; the core shares rst.
- Reset values:
  - state = S_NOKEY
  - valid shadow = 0, occupancy = 0
  - key_reg = 0, chain_reg = 0, cbc_reg = 0
  - in_ready = 0, out_valid = 0, key_ready = 0, dec_ena = 0
  - blk_count = 0
- Pipeline advance:
  - adv = ena & (~out_valid | out_ready).
  - dec_ena = adv & (state != S_NOKEY).
- Shadow pipeline:
  - LATENCY-deep valid bit plus 64-bit ciphertext copy; shifts only when dec_ena = 1.
  - Stage 0 gets in_valid & in_ready. A bubble enters when no block is accepted.
  - dec_in = in_block.
- Output:
  - out_valid = last valid bit.
  - out_block = dec_out ^ chain_reg if cbc_reg, else dec_out.
  - Combinational from dec_out. It is held stable while stalled because the core is disabled.
- CBC chaining: on an output handshake (out_valid & out_ready & ena), chain_reg <= last ciphertext copy.
- Occupancy counter (width clog2(LATENCY+1)):
  - +1 on input accept, -1 on output handshake, unchanged when both occur.
  - Never exceeds LATENCY.
- FSM:
  - S_NOKEY: in_ready = 0. key_load → load key_reg, chain_reg = iv_in, cbc_reg = cbc_in; go to S_RUN.
  - S_RUN: in_ready = adv & in_valid-independent (ready = adv). key_load with occupancy 0 → load immediately, stay in S_RUN. key_load with occupancy > 0 → latch key/IV/mode into pending registers, go to S_DRAIN.
  - S_DRAIN: in_ready = 0; pipeline keeps advancing. When occupancy reaches 0, copy pending into active registers and go to S_RUN. A further key_load while in S_DRAIN overwrites pending (last wins).
- key_ready = (state == S_RUN).
- dec_key = key_reg. Key changes only with the pipeline empty, so every in-flight block uses one key.
- Simultaneous key_load and in_valid in S_RUN with occupancy 0: the key loads and the block is not accepted that cycle (in_ready = 0 when key_load = 1).
- ena = 0: nothing advances or loads, and handshakes do not complete. out_valid may stay 1, but the sink must qualify with ena.
- Reset mid-operation: all in-flight blocks are discarded, the key is invalidated, and the FSM returns to S_NOKEY.
- Latency:
  - Accepted block appears at out_valid exactly LATENCY advancing cycles later.
  - Throughput is 1 block/cycle with no stalls.

Optional Feature:
- DEC_STATS_EN defined: port blk_count exists. It increments (wraps at 2^CNT_W) on each output handshake and clears on rst or key load.
- DEC_STATS_EN undefined: no port, no counter logic.

Decomposition:
- Package dec_ctrl_pkg: state enum (S_NOKEY, S_RUN, S_DRAIN), BLK_W=64, KEY_W=128 constants, block/key typedefs.
- One sub-module: dec_shadow_pipe (LATENCY-deep valid + ciphertext shift register with enable).

Test Plan (behavioural core stub: LATENCY=4, dec_out = dec_in ^ key[63:0] delayed 4 enabled cycles):
- No key, in_valid=1 → in_ready=0, dec_ena=0 for 10 cycles; key_load key=…_0000_00FF, ECB, then blocks 0x01,0x02 → out 0xFE,0xFD, each 4 cycles after accept.
- CBC, iv=0xAAAA, key low=0, ct 0x1111 then 0x2222 → out 0xBBBB then 0x3333.
- Stream 8 blocks with out_ready low for cycles 6–9 → dec_ena=0 and out_block held during the stall; all 8 blocks emerge in order, none lost or duplicated.
- key_load with 3 blocks in flight → in_ready=0 until the 3 old-key outputs drain; next block uses the new key; key_ready low during drain.
- rst asserted with 2 blocks in flight → next cycle out_valid=0, key_ready=0, state S_NOKEY; no stale output after reload.
- With DEC_STATS_EN: 5 handshakes → blk_count=5; key_load → 0.

Source files
------------

// File: rtl/dec_ctrl_pkg.sv
// rtl/dec_ctrl_pkg.sv - shared types and constants for the decryptor mode controller
package dec_ctrl_pkg;

    localparam int BLK_W = 64;
    localparam int KEY_W = 128;

    typedef logic [BLK_W-1:0] blk_t;
    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // One complete key context: key, chaining seed and mode.
    typedef struct packed {
        key_t key;
        blk_t iv;
        logic cbc;
    } keyset_t;

    function automatic blk_t unchain(input blk_t dec, input blk_t chain, input logic cbc);
        return cbc ? (dec ^ chain) : dec;
    endfunction

endpackage

// File: rtl/dec_shadow_pipe.sv
// rtl/dec_shadow_pipe.sv - valid bit and ciphertext shadow of the core pipeline
module dec_shadow_pipe
    import dec_ctrl_pkg::*;
#(
    parameter int LATENCY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [BLK_W-1:0] in_block,
    output logic             out_valid,
    output logic [BLK_W-1:0] out_block
);

    logic [LATENCY-1:0] vld;
    blk_t               ct [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Ciphertext copies are only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (en) begin
            ct[0] <= in_block;
            for (int i = LATENCY - 1; i > 0; i--) begin
                ct[i] <= ct[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_block = ct[LATENCY-1];

endmodule

// File: rtl/dec_mode_ctrl.sv
// rtl/dec_mode_ctrl.sv - ECB/CBC sequencing controller for the block decryptor core (DEC_STATS_EN adds blk_count)
module dec_mode_ctrl
    import dec_ctrl_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic [BLK_W-1:0] iv_in,
    input  logic             cbc_in,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             dec_ena,
    output logic [BLK_W-1:0] dec_in,
    output logic [KEY_W-1:0] dec_key,
    input  logic [BLK_W-1:0] dec_out
`ifdef DEC_STATS_EN
    ,
    output logic [CNT_W-1:0] blk_count
`endif
);

    localparam int OCC_W = $clog2(LATENCY + 1);

    state_t           state;
    key_t             key_reg;
    blk_t             chain_reg;
    logic             cbc_reg;
    keyset_t          pend;
    keyset_t          in_set;
    keyset_t          load_set;
    logic [OCC_W-1:0] occ;
    logic             occ_zero;
    logic             adv;
    logic             acc;
    logic             hs;
    logic             load_now;
    logic             pipe_valid;
    blk_t             pipe_ct;

    assign occ_zero  = (occ == '0);
    assign adv       = ena & (~out_valid | out_ready);
    assign dec_ena   = adv & (state != S_NOKEY);
    assign in_ready  = adv & (state == S_RUN) & ~key_load;
    assign acc       = in_valid & in_ready;
    assign hs        = out_valid & out_ready & ena;
    assign key_ready = (state == S_RUN);

    assign dec_in    = in_block;
    assign dec_key   = key_reg;
    assign out_valid = pipe_valid;
    assign out_block = unchain(dec_out, chain_reg, cbc_reg);
    assign in_set    = '{key: key_in, iv: iv_in, cbc: cbc_in};

    // Active key context only changes while nothing is in flight.
    always_comb begin
        load_now = 1'b0;
        load_set = in_set;
        if (ena) begin
            case (state)
                S_NOKEY: load_now = key_load;
                S_RUN:   load_now = key_load & occ_zero;
                S_DRAIN: begin
                    load_now = occ_zero;
                    if (!key_load) begin
                        load_set = pend;
                    end
                end
                default: load_now = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_NOKEY;
            key_reg   <= '0;
            chain_reg <= '0;
            cbc_reg   <= 1'b0;
            pend      <= '0;
            occ       <= '0;
        end else if (ena) begin
            if (acc && !hs) begin
                occ <= occ + OCC_W'(1);
            end else if (hs && !acc) begin
                occ <= occ - OCC_W'(1);
            end

            if (hs) begin
                chain_reg <= pipe_ct;
            end

            case (state)
                S_NOKEY: begin
                    if (key_load) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (key_load && !occ_zero) begin
                        pend  <= in_set;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (occ_zero) begin
                        state <= S_RUN;
                    end else if (key_load) begin
                        pend <= in_set;
                    end
                end
                default: state <= S_NOKEY;
            endcase

            if (load_now) begin
                key_reg   <= load_set.key;
                chain_reg <= load_set.iv;
                cbc_reg   <= load_set.cbc;
            end
        end
    end

    dec_shadow_pipe #(
        .LATENCY (LATENCY)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .en        (dec_ena),
        .in_valid  (acc),
        .in_block  (in_block),
        .out_valid (pipe_valid),
        .out_block (pipe_ct)
    );

`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load_now) begin
            cnt <= '0;
        end else if (hs) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign blk_count = cnt;
`endif

endmodule

// File: tb/tb_dec_mode_ctrl.sv
// tb/tb_dec_mode_ctrl.sv - self-checking bench for dec_mode_ctrl with a stub decryptor core
module tb_dec_mode_ctrl;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst, ena, key_load, cbc_in, in_valid, out_ready;
    logic [127:0] key_in;
    logic [63:0]  iv_in, in_block;
    logic         key_ready, in_ready, out_valid, dec_ena;
    logic [63:0]  out_block, dec_in, dec_out;
    logic [127:0] dec_key;
`ifdef DEC_STATS_EN
    logic [31:0]  blk_count;
`endif

    always #5 clk = ~clk;

    dec_mode_ctrl #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .key_load  (key_load),
        .key_in    (key_in),
        .iv_in     (iv_in),
        .cbc_in    (cbc_in),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .dec_ena   (dec_ena),
        .dec_in    (dec_in),
        .dec_key   (dec_key),
        .dec_out   (dec_out)
`ifdef DEC_STATS_EN
        ,
        .blk_count (blk_count)
`endif
    );

    // Stub core: output = input ^ key[63:0], LAT enabled cycles later.
    logic [63:0] cs [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) cs[i] <= '0;
        end else if (dec_ena) begin
            cs[0] <= dec_in ^ dec_key[63:0];
            for (int i = 1; i < LAT; i++) cs[i] <= cs[i-1];
        end
    end
    assign dec_out = cs[LAT-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pt;
        int          age;
        int          acc_t;
    } ent_t;

    ent_t         q[$];
    bit           m_keyed, m_drain, m_cbc, p_cbc;
    logic [127:0] m_key, p_key;
    logic [63:0]  m_chain, p_iv;
    int unsigned  m_cnt;
    int           tcount, n_out;
    bit           obs_acc, obs_hs;
    logic [63:0]  obs_ob;
    int           obs_lat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_key(input logic [127:0] k, input logic [63:0] iv, input bit cbc);
        m_keyed = 1; m_key = k; m_chain = iv; m_cbc = cbc; m_cnt = 0;
    endtask

    // One cycle: compare DUT against the model, then advance the model by the cycle's inputs.
    task automatic tick();
        bit   m_ov, adv, de, ir, acc, hs;
        int   occ0;
        ent_t e;
        #1;
        occ0 = q.size();
        m_ov = (occ0 > 0) && (q[0].age >= LAT);
        adv  = ena && (!m_ov || out_ready);
        de   = adv && m_keyed;
        ir   = m_keyed && !m_drain && adv && !key_load;
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, m_ov);
        chk("dec_ena", dec_ena, de);
        chk("key_ready", key_ready, m_keyed && !m_drain);
        if (m_ov) chk("out_block", out_block, q[0].pt);
        if (m_keyed) chk("dec_key", dec_key, m_key);
`ifdef DEC_STATS_EN
        chk("blk_count", blk_count, m_cnt);
`endif
        acc = 0; hs = 0;
        if (rst) begin
            q.delete(); m_keyed = 0; m_drain = 0; m_cnt = 0;
        end else begin
            acc = in_valid && ir;
            hs  = m_ov && out_ready && ena;
            if (hs) begin
                obs_ob  = q[0].pt;
                obs_lat = tcount - q[0].acc_t;
                void'(q.pop_front());
                m_cnt++;
                n_out++;
            end
            if (acc) begin
                e.pt    = in_block ^ m_key[63:0] ^ (m_cbc ? m_chain : 64'h0);
                e.age   = 0;
                e.acc_t = tcount;
                if (m_cbc) m_chain = in_block;
                q.push_back(e);
            end
            if (de) foreach (q[i]) q[i].age++;
            if (ena) begin
                if (!m_keyed) begin
                    if (key_load) apply_key(key_in, iv_in, cbc_in);
                end else if (!m_drain) begin
                    if (key_load) begin
                        if (occ0 == 0) apply_key(key_in, iv_in, cbc_in);
                        else begin
                            p_key = key_in; p_iv = iv_in; p_cbc = cbc_in; m_drain = 1;
                        end
                    end
                end else if (occ0 == 0) begin
                    if (key_load) apply_key(key_in, iv_in, cbc_in);
                    else apply_key(p_key, p_iv, p_cbc);
                    m_drain = 0;
                end else if (key_load) begin
                    p_key = key_in; p_iv = iv_in; p_cbc = cbc_in;
                end
            end
        end
        obs_acc = acc;
        obs_hs  = hs;
        tcount++;
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] ct);
        int n;
        in_valid = 1; in_block = ct;
        for (n = 0; n < 30; n++) begin
            tick();
            if (obs_acc) break;
        end
        in_valid = 0;
        chk("send_accepted", obs_acc, 1);
    endtask

    task automatic expect_out(input string tag, input logic [63:0] v);
        int n;
        for (n = 0; n < 30; n++) begin
            tick();
            if (obs_hs) break;
        end
        chk({tag, "_seen"}, obs_hs, 1);
        chk(tag, obs_ob, v);
        chk({tag, "_lat"}, obs_lat, LAT);
    endtask

    task automatic load(input logic [127:0] k, input logic [63:0] iv, input bit cbc);
        key_in = k; iv_in = iv; cbc_in = cbc; key_load = 1;
        tick();
        key_load = 0;
    endtask

    initial begin
        int k, outs0;
        rst = 1; ena = 1; key_load = 0; cbc_in = 0; in_valid = 0; out_ready = 1;
        key_in = '0; iv_in = '0; in_block = '0;
        tcount = 0; n_out = 0;
        @(negedge clk);
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_key_ready", key_ready, 0);
        chk("rst_out_valid", out_valid, 0);

        // No key loaded: input must be refused and the core idle.
        in_valid = 1; in_block = 64'h55;
        repeat (10) tick();
        in_valid = 0;

        // ECB
        load(128'h0000_0000_0000_0000_0000_0000_0000_00FF, 64'h0, 0);
        in_valid = 1; in_block = 64'h01; tick();
        chk("ecb_acc0", obs_acc, 1);
        in_block = 64'h02; tick();
        chk("ecb_acc1", obs_acc, 1);
        in_valid = 0;
        expect_out("ecb0", 64'hFE);
        expect_out("ecb1", 64'hFD);

        // CBC
        load(128'h1234_5678_0000_0000_0000_0000_0000_0000, 64'hAAAA, 1);
        in_valid = 1; in_block = 64'h1111; tick();
        in_block = 64'h2222; tick();
        in_valid = 0;
        expect_out("cbc0", 64'hBBBB);
        expect_out("cbc1", 64'h3333);

        // Stream of 8 with sink stalled on cycles 6..9
        load({$urandom, $urandom, $urandom, $urandom}, 64'h0, 0);
        outs0 = n_out; k = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid  = (k < 8);
            in_block  = 64'h100 + 64'(k);
            out_ready = !(i >= 6 && i <= 9);
            tick();
            if (obs_acc) k++;
        end
        in_valid = 0; out_ready = 1;
        chk("stream_in", k, 8);
        chk("stream_out", n_out - outs0, 8);

        // Key change with 3 blocks in flight
        send(64'hA1); send(64'hA2); send(64'hA3);
        outs0 = n_out;
        load(128'h0F0F, 64'h0, 0);
        #1;
        chk("drain_key_ready", key_ready, 0);
        send(64'hB0);
        chk("drain_outs_before_new", n_out - outs0, 3);
        expect_out("newkey", 64'hB0 ^ 64'h0F0F);

        // Reset with 2 blocks in flight
        send(64'hC1); send(64'hC2);
        rst = 1; tick(); rst = 0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_key_ready", key_ready, 0);
        repeat (8) tick();
        load(128'h3C, 64'h0, 0);
        send(64'hD0);
        expect_out("post_rst", 64'hD0 ^ 64'h3C);

`ifdef DEC_STATS_EN
        load(128'h77, 64'h0, 0);
        for (int i = 0; i < 5; i++) send(64'(i));
        repeat (12) tick();
        #1;
        chk("stats_five", blk_count, 5);
        load(128'h78, 64'h0, 0);
        #1;
        chk("stats_clear", blk_count, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_block  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            key_load  = ($urandom_range(0, 49) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            iv_in     = {$urandom, $urandom};
            cbc_in    = $urandom_range(0, 1);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; ena = 1; key_load = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 40; i++) tick();
        chk("final_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
